// File: rtl/ch_aggregate.sv
// rtl/ch_aggregate.sv - cluster-head aggregation: reads buffered readings, writes sum/max/min/count
module ch_aggregate #(
    parameter int unsigned                WORD_WIDTH  = 16,
    parameter int unsigned                ADDR_WIDTH  = 11,
    parameter logic [ADDR_WIDTH-1:0]      COUNT_ADDR  = 11'h0FF,
    parameter logic [ADDR_WIDTH-1:0]      BUF_BASE    = 11'h100,
    parameter logic [ADDR_WIDTH-1:0]      RESULT_ADDR = 11'h0F0,
    parameter int unsigned                MAX_PKTS    = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  for_aggregation,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  agg_valid
);
    localparam int unsigned CW = $clog2(MAX_PKTS + 1);
    localparam int unsigned SW = WORD_WIDTH + 6;

    typedef enum logic [2:0] {IDLE, WAIT_CNT, LATCH_CNT, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  agg_valid_q, agg_valid_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [WORD_WIDTH-1:0] max_q, max_d;
    logic [WORD_WIDTH-1:0] min_q, min_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         folded_q, folded_d;
    logic                  pipe0_q, pipe0_d;
    logic                  pipe1_q, pipe1_d;
    logic [2:0]            wr_idx_q, wr_idx_d;
    logic                  wrote_q, wrote_d;

    logic [CW-1:0]         n_clamp;
    logic [SW-1:0]         sum_fold;
    logic [WORD_WIDTH-1:0] max_fold;
    logic [WORD_WIDTH-1:0] min_fold;
    logic [WORD_WIDTH-1:0] sum_sat;

    assign n_clamp  = (data_in > WORD_WIDTH'(MAX_PKTS)) ? CW'(MAX_PKTS) : data_in[CW-1:0];
    assign sum_fold = sum_q + SW'(data_in);
    assign max_fold = (data_in > max_q) ? data_in : max_q;
    assign min_fold = (data_in < min_q) ? data_in : min_q;
    assign sum_sat  = (|sum_fold[SW-1:WORD_WIDTH]) ? {WORD_WIDTH{1'b1}} : sum_fold[WORD_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        wr_en_d     = wr_en_q;
        done_d      = done_q;
        agg_valid_d = agg_valid_q;
        sum_d       = sum_q;
        max_d       = max_q;
        min_d       = min_q;
        n_d         = n_q;
        issued_d    = issued_q;
        folded_d    = folded_q;
        pipe0_d     = pipe0_q;
        pipe1_d     = pipe1_q;
        wr_idx_d    = wr_idx_q;
        wrote_d     = wrote_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (for_aggregation) begin
                        address_d = COUNT_ADDR;
                        state_d   = WAIT_CNT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_CNT: state_d = LATCH_CNT;
            LATCH_CNT: begin
                n_d = n_clamp;
                if (n_clamp == '0) begin
                    state_d = DONE;
                end else begin
                    sum_d     = '0;
                    max_d     = '0;
                    min_d     = '1;
                    address_d = BUF_BASE;
                    issued_d  = CW'(1);
                    folded_d  = '0;
                    pipe0_d   = 1'b1;
                    pipe1_d   = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                // pipe0/pipe1 track which issued addresses have data arriving two edges later
                pipe1_d = pipe0_q;
                if (issued_q < n_q) begin
                    address_d = address_q + ADDR_WIDTH'(1);
                    issued_d  = issued_q + CW'(1);
                    pipe0_d   = 1'b1;
                end else begin
                    pipe0_d = 1'b0;
                end
                if (pipe1_q) begin
                    sum_d    = sum_fold;
                    max_d    = max_fold;
                    min_d    = min_fold;
                    folded_d = folded_q + CW'(1);
                    if (folded_q + CW'(1) == n_q) begin
                        address_d  = RESULT_ADDR;
                        data_out_d = sum_sat;
                        wr_en_d    = 1'b1;
                        wr_idx_d   = '0;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_idx_d = wr_idx_q + 3'd1;
                case (wr_idx_q)
                    3'd0: begin
                        address_d  = RESULT_ADDR + ADDR_WIDTH'(1);
                        data_out_d = max_q;
                    end
                    3'd1: begin
                        address_d  = RESULT_ADDR + ADDR_WIDTH'(2);
                        data_out_d = min_q;
                    end
                    3'd2: begin
                        address_d  = RESULT_ADDR + ADDR_WIDTH'(3);
                        data_out_d = WORD_WIDTH'(n_q);
                    end
                    3'd3: begin
                        address_d  = COUNT_ADDR;
                        data_out_d = '0;
                    end
                    default: begin
                        wr_en_d = 1'b0;
                        wrote_d = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end
            DONE: begin
                if (!done_q) begin
                    done_d      = 1'b1;
                    agg_valid_d = wrote_q;
                end else begin
                    done_d      = 1'b0;
                    agg_valid_d = 1'b0;
                    wrote_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            address_q   <= '0;
            data_out_q  <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            agg_valid_q <= 1'b0;
            sum_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            n_q         <= '0;
            issued_q    <= '0;
            folded_q    <= '0;
            pipe0_q     <= 1'b0;
            pipe1_q     <= 1'b0;
            wr_idx_q    <= '0;
            wrote_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            agg_valid_q <= agg_valid_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            min_q       <= min_d;
            n_q         <= n_d;
            issued_q    <= issued_d;
            folded_q    <= folded_d;
            pipe0_q     <= pipe0_d;
            pipe1_q     <= pipe1_d;
            wr_idx_q    <= wr_idx_d;
            wrote_q     <= wrote_d;
        end
    end

    assign address   = address_q;
    assign data_out  = data_out_q;
    assign wr_en     = wr_en_q;
    assign done      = done_q;
    assign agg_valid = agg_valid_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ch_aggregate.sv
// tb/tb_ch_aggregate.sv - directed bench for ch_aggregate with a two-edge-latency memory model
module tb_ch_aggregate;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        for_aggregation = 1'b0;
    logic [15:0] data_in;
    logic [10:0] address;
    logic [15:0] data_out;
    logic        wr_en, busy, done, agg_valid;

    logic [15:0] mem [0:2047];
    logic [15:0] rd = 16'h0;
    logic        poke_en = 1'b0;
    logic [10:0] poke_addr = 11'h0;
    logic [15:0] poke_data = 16'h0;
    int          wr_cnt = 0;

    int checks = 0;
    int errors = 0;
    int done_edge;
    logic av;
    int w0;

    ch_aggregate dut (
        .clk(clk), .nrst(nrst), .start(start), .for_aggregation(for_aggregation),
        .data_in(data_in), .address(address), .data_out(data_out), .wr_en(wr_en),
        .busy(busy), .done(done), .agg_valid(agg_valid)
    );

    always #5 clk = ~clk;
    assign data_in = rd;

    always @(posedge clk) begin
        rd <= mem[address];
        if (wr_en) begin
            mem[address] <= data_out;
            wr_cnt <= wr_cnt + 1;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Edge 0 is the edge that samples start; done_edge is the edge after which done is first seen high
    task automatic run(input logic fa, input int pulse_at, output int de, output logic v);
        int e;
        de = -1;
        v = 1'b0;
        @(negedge clk);
        start = 1'b1; for_aggregation = fa;
        @(posedge clk);
        e = 0;
        while (e < 200) begin
            @(negedge clk);
            if (done) begin
                de = e;
                v = agg_valid;
                break;
            end
            start = (e == pulse_at);
            for_aggregation = 1'b1;
            @(posedge clk);
            e++;
        end
        start = 1'b0;
        if (de < 0) check("done_timeout", 32'(de), 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("done_falls", {31'b0, done}, 32'd0);
        check("busy_falls", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        // reset values
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_address", {21'b0, address}, 32'd0);
        check("rst_data_out", {16'b0, data_out}, 32'd0);
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_agg_valid", {31'b0, agg_valid}, 32'd0);
        nrst = 1'b1;

        // skip path
        poke(11'h0FF, 16'd3);
        w0 = wr_cnt;
        run(1'b0, -1, done_edge, av);
        check("skip_done_edge", 32'(done_edge), 32'd1);
        check("skip_agg_valid", {31'b0, av}, 32'd0);
        check("skip_writes", 32'(wr_cnt - w0), 32'd0);

        // normal run: 10, 250, 7
        poke(11'h100, 16'd10);
        poke(11'h101, 16'd250);
        poke(11'h102, 16'd7);
        w0 = wr_cnt;
        run(1'b1, -1, done_edge, av);
        check("norm_done_edge", 32'(done_edge), 32'd12);
        check("norm_agg_valid", {31'b0, av}, 32'd1);
        check("norm_writes", 32'(wr_cnt - w0), 32'd5);
        check("norm_sum", {16'b0, mem[11'h0F0]}, 32'd267);
        check("norm_max", {16'b0, mem[11'h0F1]}, 32'd250);
        check("norm_min", {16'b0, mem[11'h0F2]}, 32'd7);
        check("norm_cnt", {16'b0, mem[11'h0F3]}, 32'd3);
        check("norm_clear", {16'b0, mem[11'h0FF]}, 32'd0);

        // saturation and clamp: count 40, all 0xFFFF
        poke(11'h0FF, 16'd40);
        for (int i = 0; i < 40; i++) poke(11'(11'h100 + i), 16'hFFFF);
        w0 = wr_cnt;
        run(1'b1, -1, done_edge, av);
        check("sat_done_edge", 32'(done_edge), 32'd41);
        check("sat_sum", {16'b0, mem[11'h0F0]}, 32'h0000_FFFF);
        check("sat_max", {16'b0, mem[11'h0F1]}, 32'h0000_FFFF);
        check("sat_min", {16'b0, mem[11'h0F2]}, 32'h0000_FFFF);
        check("sat_cnt", {16'b0, mem[11'h0F3]}, 32'd32);
        check("sat_writes", 32'(wr_cnt - w0), 32'd5);

        // empty buffer
        poke(11'h0F0, 16'h1234);
        w0 = wr_cnt;
        run(1'b1, -1, done_edge, av);
        check("empty_done_edge", 32'(done_edge), 32'd3);
        check("empty_agg_valid", {31'b0, av}, 32'd0);
        check("empty_writes", 32'(wr_cnt - w0), 32'd0);
        check("empty_untouched", {16'b0, mem[11'h0F0]}, 32'h1234);

        // start pulsed during READ: 5, 9, 2
        poke(11'h0FF, 16'd3);
        poke(11'h100, 16'd5);
        poke(11'h101, 16'd9);
        poke(11'h102, 16'd2);
        w0 = wr_cnt;
        run(1'b1, 4, done_edge, av);
        check("pulse_done_edge", 32'(done_edge), 32'd12);
        check("pulse_writes", 32'(wr_cnt - w0), 32'd5);
        check("pulse_sum", {16'b0, mem[11'h0F0]}, 32'd16);
        check("pulse_max", {16'b0, mem[11'h0F1]}, 32'd9);
        check("pulse_min", {16'b0, mem[11'h0F2]}, 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pulse_no_rerun", {31'b0, busy}, 32'd0);

        // reset during READ, then a fresh run: 100, 3, 50
        poke(11'h0FF, 16'd3);
        poke(11'h100, 16'd100);
        poke(11'h101, 16'd3);
        poke(11'h102, 16'd50);
        poke(11'h0F0, 16'hAAAA);
        @(negedge clk);
        start = 1'b1; for_aggregation = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", {31'b0, busy}, 32'd1);
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("mid_rst_address", {21'b0, address}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_result", {16'b0, mem[11'h0F0]}, 32'hAAAA);
        nrst = 1'b1;
        w0 = wr_cnt;
        run(1'b1, -1, done_edge, av);
        check("fresh_done_edge", 32'(done_edge), 32'd12);
        check("fresh_agg_valid", {31'b0, av}, 32'd1);
        check("fresh_sum", {16'b0, mem[11'h0F0]}, 32'd153);
        check("fresh_max", {16'b0, mem[11'h0F1]}, 32'd100);
        check("fresh_min", {16'b0, mem[11'h0F2]}, 32'd3);
        check("fresh_writes", 32'(wr_cnt - w0), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
